// File: rtl/spu_decode_issue_stage.sv
// SPU decode/issue stage: field decode, immediate generation, operand forwarding,
// load-use stall, in-stage branch-equal resolution and a registered ID/EX slot.
module spu_decode_issue_stage #(
    parameter int unsigned DATA_W    = 128,
    parameter int unsigned PC_W      = 11,
    parameter int unsigned RADDR_W   = 7,
    parameter int unsigned FWD_N     = 2,
    parameter bit          IMM_SPLAT = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instr,
    input  logic [PC_W-1:0]            in_pc_plus8,
    input  logic [1:0]                 imm_sel,
    input  logic [2:0]                 use_mask,
    input  logic                       branch_ctrl,
    output logic [RADDR_W-1:0]         rf_ra_addr,
    output logic [RADDR_W-1:0]         rf_rb_addr,
    output logic [RADDR_W-1:0]         rf_rc_addr,
    input  logic [DATA_W-1:0]          rf_ra_data,
    input  logic [DATA_W-1:0]          rf_rb_data,
    input  logic [DATA_W-1:0]          rf_rc_data,
    input  logic [FWD_N-1:0]           fwd_valid,
    input  logic [FWD_N*RADDR_W-1:0]   fwd_reg,
    input  logic [FWD_N*DATA_W-1:0]    fwd_data,
    input  logic                       ex_load_valid,
    input  logic [RADDR_W-1:0]         ex_load_rt,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_opa,
    output logic [DATA_W-1:0]          out_opb,
    output logic [DATA_W-1:0]          out_opc,
    output logic [DATA_W-1:0]          out_imm,
    output logic [RADDR_W-1:0]         out_rt,
    output logic [RADDR_W-1:0]         out_rrr,
    output logic [PC_W-1:0]            out_pc_plus8,
    output logic                       branch_taken,
    output logic [PC_W-1:0]            branch_target
);

    localparam int unsigned Lanes = DATA_W / 32;

    logic [RADDR_W-1:0] ra_addr, rb_addr, rc_addr, rt_addr, rrr_addr;
    logic [31:0]        imm32;
    logic [DATA_W-1:0]  imm_full;
    logic [DATA_W-1:0]  opa, opb, opc;
    logic [PC_W-1:0]    imm_lo, target_d;
    logic               stall, accept, take;
    logic               unused_instr_hi;

    logic               out_valid_q;
    logic [DATA_W-1:0]  opa_q, opb_q, opc_q, imm_q;
    logic [RADDR_W-1:0] rt_q, rrr_q;
    logic [PC_W-1:0]    pc_q, target_q;
    logic               taken_q;
    // Set by a taken branch; the next accepted instruction is dropped.
    logic               squash_q;

    assign ra_addr  = RADDR_W'(in_instr[13:7]);
    assign rb_addr  = RADDR_W'(in_instr[20:14]);
    assign rc_addr  = RADDR_W'(in_instr[6:0]);
    assign rt_addr  = RADDR_W'(in_instr[6:0]);
    assign rrr_addr = RADDR_W'(in_instr[27:21]);
    assign unused_instr_hi = ^in_instr[31:28];

    assign rf_ra_addr = ra_addr;
    assign rf_rb_addr = rb_addr;
    assign rf_rc_addr = rc_addr;

    always_comb begin
        imm32 = '0;
        unique case (imm_sel)
            2'b00: imm32 = {{25{in_instr[20]}}, in_instr[20:14]};
            2'b01: imm32 = {{22{in_instr[23]}}, in_instr[23:14]};
            2'b10: imm32 = {{16{in_instr[22]}}, in_instr[22:7]};
            2'b11: imm32 = {14'b0, in_instr[24:7]};
            default: imm32 = '0;
        endcase
    end

    // Mode 11 always leaves bit 31 clear, so bit 31 is the extension bit in every mode.
    always_comb begin
        imm_full = '0;
        if (IMM_SPLAT) begin
            for (int unsigned l = 0; l < Lanes; l++) begin
                imm_full[l*32 +: 32] = imm32;
            end
        end else begin
            imm_full[31:0] = imm32;
            for (int unsigned b = 32; b < DATA_W; b++) begin
                imm_full[b] = imm32[31];
            end
        end
    end

    // Scan from the oldest source down so the lowest matching index wins.
    function automatic logic [DATA_W-1:0] fwd_pick(input logic [RADDR_W-1:0] addr,
                                                   input logic [DATA_W-1:0]  rf_data);
        logic [DATA_W-1:0] res;
        res = rf_data;
        for (int i = int'(FWD_N) - 1; i >= 0; i--) begin
            if (fwd_valid[i] && (fwd_reg[i*RADDR_W +: RADDR_W] == addr)) begin
                res = fwd_data[i*DATA_W +: DATA_W];
            end
        end
        return res;
    endfunction

    assign opa = fwd_pick(ra_addr, rf_ra_data);
    assign opb = fwd_pick(rb_addr, rf_rb_data);
    assign opc = fwd_pick(rc_addr, rf_rc_data);

    assign stall = in_valid && ex_load_valid &&
                   ((use_mask[0] && (ra_addr == ex_load_rt)) ||
                    (use_mask[1] && (rb_addr == ex_load_rt)) ||
                    (use_mask[2] && (rc_addr == ex_load_rt)));

    assign in_ready = !reset && !stall && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign take     = accept && !squash_q && branch_ctrl && (opa == opb);

    assign imm_lo   = imm_full[PC_W-1:0];
    assign target_d = in_pc_plus8 + (imm_lo << 3);

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            opa_q       <= '0;
            opb_q       <= '0;
            opc_q       <= '0;
            imm_q       <= '0;
            rt_q        <= '0;
            rrr_q       <= '0;
            pc_q        <= '0;
            taken_q     <= 1'b0;
            target_q    <= '0;
            squash_q    <= 1'b0;
        end else begin
            taken_q <= take;
            if (take) begin
                target_q <= target_d;
            end

            if (take) begin
                squash_q <= 1'b1;
            end else if (accept) begin
                squash_q <= 1'b0;
            end

            if (accept && !squash_q) begin
                out_valid_q <= 1'b1;
                opa_q       <= opa;
                opb_q       <= opb;
                opc_q       <= opc;
                imm_q       <= imm_full;
                rt_q        <= rt_addr;
                rrr_q       <= rrr_addr;
                pc_q        <= in_pc_plus8;
            end else if (!out_valid_q || out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid     = out_valid_q;
    assign out_opa       = opa_q;
    assign out_opb       = opb_q;
    assign out_opc       = opc_q;
    assign out_imm       = imm_q;
    assign out_rt        = rt_q;
    assign out_rrr       = rrr_q;
    assign out_pc_plus8  = pc_q;
    assign branch_taken  = taken_q;
    assign branch_target = target_q;

endmodule

// File: tb/tb_spu_decode_issue_stage.sv
// Bench for spu_decode_issue_stage: vector table with a scoreboard queue, plus
// hand-written branch, squash, backpressure and reset sequences.
module tb_spu_decode_issue_stage;

    localparam int DW = 128;
    localparam int PW = 11;
    localparam int RW = 7;
    localparam int FN = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic [31:0]     in_instr;
    logic [PW-1:0]   in_pc_plus8;
    logic [1:0]      imm_sel;
    logic [2:0]      use_mask;
    logic            branch_ctrl;
    logic [DW-1:0]   rf_ra_data, rf_rb_data, rf_rc_data;
    logic [FN-1:0]   fwd_valid;
    logic [FN*RW-1:0] fwd_reg;
    logic [FN*DW-1:0] fwd_data;
    logic            ex_load_valid;
    logic [RW-1:0]   ex_load_rt;
    logic            out_ready;

    logic            in_ready, out_valid, branch_taken;
    logic [RW-1:0]   rf_ra_addr, rf_rb_addr, rf_rc_addr, out_rt, out_rrr;
    logic [DW-1:0]   out_opa, out_opb, out_opc, out_imm;
    logic [PW-1:0]   out_pc_plus8, branch_target;

    logic            s_in_ready, s_out_valid, s_branch_taken;
    logic [RW-1:0]   s_rf_ra_addr, s_rf_rb_addr, s_rf_rc_addr, s_out_rt, s_out_rrr;
    logic [DW-1:0]   s_out_opa, s_out_opb, s_out_opc, s_out_imm;
    logic [PW-1:0]   s_out_pc_plus8, s_branch_target;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    spu_decode_issue_stage #(
        .DATA_W(DW), .PC_W(PW), .RADDR_W(RW), .FWD_N(FN), .IMM_SPLAT(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc_plus8(in_pc_plus8), .imm_sel(imm_sel),
        .use_mask(use_mask), .branch_ctrl(branch_ctrl),
        .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr), .rf_rc_addr(rf_rc_addr),
        .rf_ra_data(rf_ra_data), .rf_rb_data(rf_rb_data), .rf_rc_data(rf_rc_data),
        .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
        .ex_load_valid(ex_load_valid), .ex_load_rt(ex_load_rt),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opa(out_opa), .out_opb(out_opb), .out_opc(out_opc), .out_imm(out_imm),
        .out_rt(out_rt), .out_rrr(out_rrr), .out_pc_plus8(out_pc_plus8),
        .branch_taken(branch_taken), .branch_target(branch_target)
    );

    spu_decode_issue_stage #(
        .DATA_W(DW), .PC_W(PW), .RADDR_W(RW), .FWD_N(FN), .IMM_SPLAT(1'b1)
    ) dut_s (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_instr(in_instr), .in_pc_plus8(in_pc_plus8), .imm_sel(imm_sel),
        .use_mask(use_mask), .branch_ctrl(branch_ctrl),
        .rf_ra_addr(s_rf_ra_addr), .rf_rb_addr(s_rf_rb_addr), .rf_rc_addr(s_rf_rc_addr),
        .rf_ra_data(rf_ra_data), .rf_rb_data(rf_rb_data), .rf_rc_data(rf_rc_data),
        .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
        .ex_load_valid(ex_load_valid), .ex_load_rt(ex_load_rt),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_opa(s_out_opa), .out_opb(s_out_opb), .out_opc(s_out_opc), .out_imm(s_out_imm),
        .out_rt(s_out_rt), .out_rrr(s_out_rrr), .out_pc_plus8(s_out_pc_plus8),
        .branch_taken(s_branch_taken), .branch_target(s_branch_target)
    );

    typedef struct {
        logic [31:0]    instr;
        logic [1:0]     isel;
        logic [2:0]     umask;
        logic [DW-1:0]  ra_d, rb_d, rc_d;
        logic [FN-1:0]  fv;
        logic [FN*RW-1:0] fr;
        logic [FN*DW-1:0] fd;
        logic           lv;
        logic [RW-1:0]  lrt;
        logic           stall;
        logic [DW-1:0]  opa, opb, opc, imm, imm_s;
    } vec_t;

    typedef struct {
        logic [DW-1:0] opa, opb, opc, imm, imm_s;
        logic [RW-1:0] rt, rrr;
        logic [PW-1:0] pc;
    } exp_t;

    vec_t vecs[12];
    exp_t sb[$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [6:0] rc, input logic [6:0] ra, input logic [6:0] rb,
                                input logic [10:0] hi, input logic [1:0] isel,
                                input logic [2:0] um, input logic [DW-1:0] ra_d,
                                input logic [DW-1:0] rb_d, input logic [DW-1:0] rc_d,
                                input logic [1:0] fv, input logic [13:0] fr,
                                input logic [255:0] fd, input logic lv, input logic [6:0] lrt,
                                input logic st, input logic [DW-1:0] opa,
                                input logic [DW-1:0] opb, input logic [DW-1:0] opc,
                                input logic [DW-1:0] imm, input logic [DW-1:0] imm_s);
        vec_t v;
        v.instr = {hi, rb, ra, rc};
        v.isel = isel; v.umask = um;
        v.ra_d = ra_d; v.rb_d = rb_d; v.rc_d = rc_d;
        v.fv = fv; v.fr = fr; v.fd = fd; v.lv = lv; v.lrt = lrt; v.stall = st;
        v.opa = opa; v.opb = opb; v.opc = opc; v.imm = imm; v.imm_s = imm_s;
        return v;
    endfunction

    task automatic set_instr(input logic [6:0] rc, input logic [6:0] ra, input logic [6:0] rb,
                             input logic [10:0] hi);
        in_instr = {hi, rb, ra, rc};
    endtask

    task automatic idle_inputs();
        in_valid = 0; branch_ctrl = 0; imm_sel = 0; use_mask = 3'b111;
        fwd_valid = 0; fwd_reg = 0; fwd_data = 0; ex_load_valid = 0; ex_load_rt = 0;
        rf_ra_data = 0; rf_rb_data = 0; rf_rc_data = 0; in_pc_plus8 = 0; in_instr = 0;
    endtask

    task automatic apply(input vec_t v, input logic [PW-1:0] pc);
        exp_t e;
        @(negedge clk);
        in_valid = 1; branch_ctrl = 0; out_ready = 1;
        in_instr = v.instr; in_pc_plus8 = pc; imm_sel = v.isel; use_mask = v.umask;
        rf_ra_data = v.ra_d; rf_rb_data = v.rb_d; rf_rc_data = v.rc_d;
        fwd_valid = v.fv; fwd_reg = v.fr; fwd_data = v.fd;
        ex_load_valid = v.lv; ex_load_rt = v.lrt;
        #1;
        check("in_ready", DW'(in_ready), DW'(!v.stall));
        check("rf_ra_addr", DW'(rf_ra_addr), DW'(v.instr[13:7]));
        check("rf_rb_addr", DW'(rf_rb_addr), DW'(v.instr[20:14]));
        check("rf_rc_addr", DW'(rf_rc_addr), DW'(v.instr[6:0]));
        if (!v.stall) begin
            e.opa = v.opa; e.opb = v.opb; e.opc = v.opc; e.imm = v.imm; e.imm_s = v.imm_s;
            e.rt = v.instr[6:0]; e.rrr = v.instr[27:21]; e.pc = pc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        check("out_valid", DW'(out_valid), DW'(sb.size() > 0));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("out_opa", out_opa, e.opa);
            check("out_opb", out_opb, e.opb);
            check("out_opc", out_opc, e.opc);
            check("out_imm", out_imm, e.imm);
            check("out_imm_splat", s_out_imm, e.imm_s);
            check("out_rt", DW'(out_rt), DW'(e.rt));
            check("out_rrr", DW'(out_rrr), DW'(e.rrr));
            check("out_pc_plus8", DW'(out_pc_plus8), DW'(e.pc));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1; out_ready = 1;
        idle_inputs();

        // Reset behaviour
        #1;
        check("in_ready_in_reset", DW'(in_ready), '0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 0;
        @(posedge clk); #1;
        check("reset_out_valid", DW'(out_valid), '0);
        check("reset_branch_taken", DW'(branch_taken), '0);
        check("reset_out_imm", out_imm, '0);
        check("reset_branch_target", DW'(branch_target), '0);

        // rc, ra, rb, hi, isel, umask, ra_d, rb_d, rc_d, fv, fr, fd, lv, lrt, stall,
        // opa, opb, opc, imm, imm_splat
        vecs[0]  = mk(7'h01, 7'h02, 7'h7F, 11'h000, 2'b00, 3'b111, 'h11, 'h22, 'h33,
                      2'b00, 14'h0, 256'h0, 0, 7'h0, 0, 'h11, 'h22, 'h33, '1, '1);
        vecs[1]  = mk(7'h00, 7'h7F, 7'h7F, 11'h00F, 2'b11, 3'b111, 'h44, 'h55, 'h66,
                      2'b00, 14'h0, 256'h0, 0, 7'h0, 0, 'h44, 'h55, 'h66,
                      128'h3FFFF, {4{32'h0003FFFF}});
        vecs[2]  = mk(7'h03, 7'h01, 7'h00, 11'h002, 2'b10, 3'b111, 'h1, 'h2, 'h3,
                      2'b00, 14'h0, 256'h0, 0, 7'h0, 0, 'h1, 'h2, 'h3,
                      {{96{1'b1}}, 32'hFFFF8001}, {4{32'hFFFF8001}});
        vecs[3]  = mk(7'h07, 7'h05, 7'h06, 11'h000, 2'b00, 3'b111, 'h1, 'h66, 'h77,
                      2'b11, {7'd5, 7'd5}, {128'hBB, 128'hAA}, 0, 7'h0, 0,
                      'hAA, 'h66, 'h77, 'h6, {4{32'h6}});
        vecs[4]  = mk(7'h07, 7'h05, 7'h06, 11'h000, 2'b00, 3'b111, 'h1, 'h66, 'h77,
                      2'b00, {7'd5, 7'd5}, {128'hBB, 128'hAA}, 0, 7'h0, 0,
                      'h1, 'h66, 'h77, 'h6, {4{32'h6}});
        vecs[5]  = mk(7'h07, 7'h05, 7'h06, 11'h000, 2'b00, 3'b111, 'h1, 'h66, 'h77,
                      2'b11, {7'd5, 7'd6}, {128'hBB, 128'hAA}, 0, 7'h0, 0,
                      'hBB, 'hAA, 'h77, 'h6, {4{32'h6}});
        vecs[6]  = mk(7'h02, 7'h01, 7'h09, 11'h000, 2'b00, 3'b010, 'h1, 'h2, 'h3,
                      2'b00, 14'h0, 256'h0, 1, 7'h09, 1, '0, '0, '0, '0, '0);
        vecs[7]  = mk(7'h02, 7'h01, 7'h09, 11'h000, 2'b00, 3'b001, 'h1, 'h2, 'h3,
                      2'b00, 14'h0, 256'h0, 1, 7'h09, 0, 'h1, 'h2, 'h3, 'h9, {4{32'h9}});
        vecs[8]  = mk(7'h09, 7'h01, 7'h02, 11'h000, 2'b00, 3'b100, 'h1, 'h2, 'h3,
                      2'b00, 14'h0, 256'h0, 1, 7'h09, 1, '0, '0, '0, '0, '0);
        vecs[9]  = mk(7'h03, 7'h09, 7'h02, 11'h000, 2'b00, 3'b110, 'hA, 'hB, 'hC,
                      2'b00, 14'h0, 256'h0, 1, 7'h09, 0, 'hA, 'hB, 'hC, 'h2, {4{32'h2}});
        vecs[10] = mk(7'h07, 7'h01, 7'h04, 11'h000, 2'b00, 3'b111, 'h1, 'h2, 'h3,
                      2'b10, {7'd7, 7'd7}, {128'hCC, 128'hDD}, 0, 7'h0, 0,
                      'h1, 'h2, 'hCC, 'h4, {4{32'h4}});
        vecs[11] = mk(7'h05, 7'h06, 7'h01, 11'h004, 2'b01, 3'b111, 'h1, 'h2, 'h3,
                      2'b00, 14'h0, 256'h0, 0, 7'h0, 0, 'h1, 'h2, 'h3,
                      {{96{1'b1}}, 32'hFFFFFE01}, {4{32'hFFFFFE01}});

        for (int i = 0; i < 12; i++) begin
            apply(vecs[i], PW'(16 + i * 8));
        end
        @(negedge clk) idle_inputs();
        @(posedge clk); #1;
        check("scoreboard_empty", DW'(sb.size()), '0);

        // Taken branch with wrap, then one squashed and one issued instruction
        @(negedge clk);
        in_valid = 1; branch_ctrl = 1; out_ready = 1; imm_sel = 2'b00; use_mask = 3'b011;
        set_instr(7'h04, 7'h03, 7'h02, 11'h000);
        in_pc_plus8 = 11'h7F8; rf_ra_data = 'h1234; rf_rb_data = 'h1234;
        @(posedge clk); #1;
        check("br_out_valid", DW'(out_valid), 'd1);
        check("br_taken", DW'(branch_taken), 'd1);
        check("br_target_wrap", DW'(branch_target), 'h008);
        check("br_pc_plus8", DW'(out_pc_plus8), 'h7F8);
        branch_ctrl = 0; set_instr(7'h11, 7'h01, 7'h02, 11'h000); rf_rb_data = 'h5;
        #1;
        check("squash_in_ready", DW'(in_ready), 'd1);
        @(posedge clk); #1;
        check("squash_out_valid", DW'(out_valid), '0);
        check("br_taken_one_cycle", DW'(branch_taken), '0);
        set_instr(7'h12, 7'h01, 7'h02, 11'h000);
        @(posedge clk); #1;
        check("post_squash_valid", DW'(out_valid), 'd1);
        check("post_squash_rt", DW'(out_rt), 'h12);

        // Branch with unequal operands does not redirect nor squash
        branch_ctrl = 1; set_instr(7'h13, 7'h03, 7'h02, 11'h000);
        rf_ra_data = 'h1; rf_rb_data = 'h2;
        @(posedge clk); #1;
        check("br_ne_taken", DW'(branch_taken), '0);
        branch_ctrl = 0; set_instr(7'h14, 7'h01, 7'h02, 11'h000);
        @(posedge clk); #1;
        check("br_ne_next_valid", DW'(out_valid), 'd1);
        check("br_ne_next_rt", DW'(out_rt), 'h14);

        // Taken branch followed by a stalled instruction: squash applies once it is accepted
        branch_ctrl = 1; set_instr(7'h15, 7'h03, 7'h02, 11'h000);
        rf_ra_data = 'h77; rf_rb_data = 'h77; in_pc_plus8 = 11'h100;
        @(posedge clk); #1;
        check("br2_taken", DW'(branch_taken), 'd1);
        check("br2_target", DW'(branch_target), 'h110);
        branch_ctrl = 0; set_instr(7'h16, 7'h01, 7'h09, 11'h000); use_mask = 3'b010;
        ex_load_valid = 1; ex_load_rt = 7'h09;
        #1;
        check("br2_stall_ready", DW'(in_ready), '0);
        @(posedge clk); #1;
        check("br2_bubble", DW'(out_valid), '0);
        check("br2_taken_off", DW'(branch_taken), '0);
        ex_load_valid = 0;
        #1;
        check("br2_unstall_ready", DW'(in_ready), 'd1);
        @(posedge clk); #1;
        check("br2_squashed", DW'(out_valid), '0);
        set_instr(7'h22, 7'h01, 7'h02, 11'h000);
        @(posedge clk); #1;
        check("br2_next_valid", DW'(out_valid), 'd1);
        check("br2_next_rt", DW'(out_rt), 'h22);
        in_valid = 0;
        @(posedge clk); #1;

        // Backpressure: hold for 3 cycles, then the waiting instruction issues
        in_valid = 1; out_ready = 0; imm_sel = 2'b00; use_mask = 3'b111;
        set_instr(7'h31, 7'h01, 7'h05, 11'h000); rf_ra_data = 'hA1;
        @(posedge clk); #1;
        set_instr(7'h32, 7'h01, 7'h06, 11'h000); rf_ra_data = 'hA2;
        for (int k = 0; k < 3; k++) begin
            check("bp_in_ready", DW'(in_ready), '0);
            check("bp_out_valid", DW'(out_valid), 'd1);
            check("bp_out_rt", DW'(out_rt), 'h31);
            check("bp_out_imm", out_imm, 'h5);
            check("bp_out_opa", out_opa, 'hA1);
            @(posedge clk); #1;
        end
        out_ready = 1;
        #1;
        check("bp_release_ready", DW'(in_ready), 'd1);
        @(posedge clk); #1;
        check("bp_next_valid", DW'(out_valid), 'd1);
        check("bp_next_rt", DW'(out_rt), 'h32);
        check("bp_next_opa", out_opa, 'hA2);

        // Reset during a hold discards the slot
        in_valid = 0; out_ready = 0; reset = 1;
        @(posedge clk); #1;
        reset = 0;
        check("rst_hold_valid", DW'(out_valid), '0);
        check("rst_hold_opa", out_opa, '0);
        check("rst_hold_rt", DW'(out_rt), '0);
        check("rst_hold_imm", out_imm, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spu_decode_issue_stage.md
# spu_decode_issue_stage

Parametrised SPU instruction-decode stage with a registered ID/EX output slot: field extraction, mode-selected immediate generation, N-source operand forwarding, load-use stall detection and in-stage branch-equal resolution. Sits between the IF/ID register and the execute pipes. It drives external register-file read addresses and consumes the returned read data. Upstream and downstream use a valid/ready handshake.

## Interface
- DATA_W, 128, operand/immediate width
- PC_W, 11, program-counter width
- RADDR_W, 7, register address width
- FWD_N, 2, number of forwarding sources; index 0 is youngest
- IMM_SPLAT, 0, 1 = immediates replicated into every 32-bit lane; 0 = extended to DATA_W
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid / in_ready  in / out  1  upstream handshake
- in_instr  in  32  instruction word
- in_pc_plus8  in  PC_W  PC of the instruction plus 8
- imm_sel  in  2  immediate mode, from the control unit
- use_mask  in  3  {RC,RB,RA} operand-used flags
- branch_ctrl  in  1  instruction is a branch-if-equal
- rf_ra_addr / rf_rb_addr / rf_rc_addr  out  RADDR_W each  = in_instr[13:7] / [20:14] / [6:0]
- rf_ra_data / rf_rb_data / rf_rc_data  in  DATA_W each  register-file read data, same cycle
- fwd_valid  in  FWD_N  forwarding source valid
- fwd_reg  in  FWD_N*RADDR_W  forwarding destination registers
- fwd_data  in  FWD_N*DATA_W  forwarding data
- ex_load_valid, ex_load_rt  in  1, RADDR_W  load in EX, data not yet forwardable
- out_valid / out_ready  out / in  1  downstream handshake
- out_opa / out_opb / out_opc  out  DATA_W  forwarded operands
- out_imm  out  DATA_W  immediate
- out_rt / out_rrr  out  RADDR_W  = in_instr[6:0] / in_instr[27:21]
- out_pc_plus8  out  PC_W  passed through
- branch_taken  out  1  one-cycle redirect pulse
- branch_target  out  PC_W  redirect address, valid while branch_taken = 1

## Operation
- Field decode is combinational from in_instr. The RF address outputs are always driven.
- Forwarding, per operand: the lowest index i with fwd_valid[i] and fwd_reg[i] == the operand address supplies fwd_data[i]. With no match, the RF data is used. No register is hard-wired to zero.
- Immediate modes (E = signed or zero extend to 32 bits when IMM_SPLAT=1, to DATA_W otherwise):
  - 00: sign-extend instr[20:14]
  - 01: sign-extend instr[23:14]
  - 10: sign-extend instr[22:7]
  - 11: zero-extend instr[24:7]
  - When IMM_SPLAT=1, the 32-bit value is copied into all DATA_W/32 lanes.
- Stall: asserted when in_valid, ex_load_valid, and any operand with use_mask set has an address equal to ex_load_rt.
- in_ready = !reset && !stall && (!out_valid || out_ready).
- Accept: occurs when in_valid && in_ready. The output slot loads all decoded fields and sets out_valid=1.
- Bubble: when stalled and the slot is free or draining (!out_valid || out_ready), out_valid is cleared.
- Hold: when out_valid && !out_ready, every output stays stable.
- Branch resolution:
  - On accept with branch_ctrl=1, the forwarded RA and RB are compared over the full DATA_W.
  - If equal, branch_taken=1 on the next cycle, with branch_target = in_pc_plus8 + (imm[PC_W-1:0] << 3), truncated mod 2^PC_W (wrap-around allowed).
  - The branch instruction itself still issues downstream.
- Squash: in the cycle where branch_taken=1, any instruction offered upstream is accepted, if in_ready allows, and discarded. out_valid is not set by it. Only one instruction is squashed.
- Reset: out_valid=0, branch_taken=0, branch_target=0, and all data outputs are 0. Reset asserted mid-stall or mid-hold discards the slot contents.

## Timing
- Decode-to-output latency: 1 cycle (accept at edge N, outputs valid after edge N).
- branch_taken is registered and lasts exactly 1 cycle, the cycle after the branch is accepted.
- Forward match, stall and in_ready are combinational in the same cycle as in_valid. Forwarded data is sampled only at the accept edge.
- Back-to-back accepts are supported at 1 instruction per cycle when out_ready=1.
- Simultaneous events:
  - A stall during a downstream hold adds nothing (in_ready=0 already).
  - A branch accepted while the following instruction is stalled: branch_taken still pulses, and the stalled instruction is squashed when it is later accepted.

## Test plan
- Reset check: with reset=1 for 2 cycles, then released with in_valid=0 -> out_valid=0, branch_taken=0, out_imm=0.
- Immediate modes: imm_sel=00 with instr[20:14]=7'h7F -> out_imm all ones. imm_sel=11 with instr[24:7]=18'h3FFFF -> out_imm=0x3FFFF. IMM_SPLAT=1 with imm_sel=10 and field 16'h8001 -> every lane = 0xFFFF8001.
- Forward priority: RA=5, RF data=1, fwd_valid=2'b11, fwd_reg={5,5}, fwd_data={0xBB,0xAA} (index 0 = 0xAA) -> out_opa=0xAA. With fwd_valid=0 -> out_opa=1.
- Load-use stall: ex_load_valid=1, ex_load_rt=9, RB=9, use_mask=3'b010 -> in_ready=0 and out_valid=0 next cycle. Same case with use_mask=3'b001 -> accepted.
- Branch taken with wrap: pc_plus8=11'h7F8, imm low bits=2, RA data=RB data -> branch_taken for 1 cycle with target 11'h008. The next offered instruction is accepted and not issued.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0. On release, the next instruction issues 1 cycle later.
